// File: rtl/fir_mac_filter.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_filter
// Brief    : TAPS-tap unsigned FIR filter with run-time-loadable coefficients.
//            A single multiply-accumulate is time-multiplexed across the taps,
//            one tap per clock. The result is scaled by a right shift,
//            saturated to OUT_W bits and flagged with a one-cycle out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_filter #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 5,
    parameter int OUT_W     = 10,
    parameter int OUT_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        x,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic [OUT_W-1:0]         dataout,
    output logic                     out_valid,
    output logic                     sat
);

    localparam int c_addr_w = $clog2(TAPS);
    localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS);
    localparam int c_prod_w = DATA_W + COEF_W;

    // Largest value representable on the output, widened to the accumulator.
    localparam logic [ACC_W-1:0] c_out_max = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mac  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]          r_state;
    logic [c_addr_w-1:0] r_idx;
    logic [DATA_W-1:0]   r_tap  [TAPS];
    logic [COEF_W-1:0]   r_coef [TAPS];
    logic [ACC_W-1:0]    r_acc;
    logic [OUT_W-1:0]    r_dataout;
    logic                r_out_valid;
    logic                r_sat;

    logic                w_accept;
    logic                w_coef_wr;
    logic                w_last;
    logic [c_prod_w-1:0] w_prod;
    logic [ACC_W-1:0]    w_shifted;
    logic                w_over;

    assign in_ready  = (r_state == c_st_idle);
    assign w_accept  = in_ready && in_valid;
    // Out-of-range addresses are compared one bit wider so TAPS need not be a power of two.
    assign w_coef_wr = coef_we && in_ready &&
                       ({1'b0, coef_addr} < (c_addr_w+1)'(TAPS));
    assign w_last    = (r_idx == c_addr_w'(TAPS-1));
    assign w_prod    = c_prod_w'(r_tap[r_idx]) * c_prod_w'(r_coef[r_idx]);
    assign w_shifted = r_acc >> OUT_SHIFT;
    assign w_over    = (w_shifted > c_out_max);

    assign dataout   = r_dataout;
    assign out_valid = r_out_valid;
    assign sat       = r_sat;

    // Delay line: shifts in a new sample only when one is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) r_tap[k] <= '0;
        end else if (w_accept) begin
            r_tap[0] <= x;
            for (int k = 1; k < TAPS; k++) r_tap[k] <= r_tap[k-1];
        end
    end

    // Coefficient bank: defaults h[k] = 2^(COEF_W-TAPS+k); writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) r_coef[k] <= COEF_W'(1) << (COEF_W - TAPS + k);
        end else if (w_coef_wr) begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_addr == c_addr_w'(k)) r_coef[k] <= coef_data;
            end
        end
    end

    // Sequencer: accept, accumulate one tap per cycle, then scale/saturate and publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_acc       <= '0;
            r_dataout   <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= c_st_mac;
                    end
                end
                c_st_mac: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_idx   <= r_idx + c_addr_w'(1);
                    end
                end
                c_st_done: begin
                    r_dataout   <= w_over ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];
                    r_sat       <= w_over;
                    r_out_valid <= 1'b1;
                    r_state     <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_filter
// Brief    : Self-checking bench for fir_mac_filter against a sum-of-products
//            reference model of the filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_filter;

    localparam int DATA_W    = 8;
    localparam int COEF_W    = 8;
    localparam int TAPS      = 5;
    localparam int OUT_W     = 10;
    localparam int OUT_SHIFT = 8;
    localparam int AW        = $clog2(TAPS);
    localparam int OUT_MAX   = (1 << OUT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] x;
    logic              in_valid;
    logic              in_ready;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic [OUT_W-1:0]  dataout;
    logic              out_valid;
    logic              sat;

    fir_mac_filter #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .dataout(dataout), .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: sample history (newest first) and coefficient values.
    int m_hist [TAPS];
    int m_coef [TAPS];
    int exp_out;
    int exp_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_hist[k] = 0;
            m_coef[k] = 1 << (COEF_W - TAPS + k);
        end
    endtask

    // y = sum(h[k] * x[n-k]) >> OUT_SHIFT, clipped to the output range.
    task automatic model_push(input int v);
        longint sum;
        longint sh;
        for (int k = TAPS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = v;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += longint'(m_hist[k]) * longint'(m_coef[k]);
        sh = sum >> OUT_SHIFT;
        if (sh > OUT_MAX) begin
            exp_out = OUT_MAX;
            exp_sat = 1;
        end else begin
            exp_out = int'(sh);
            exp_sat = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data, input bit expect_taken);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = COEF_W'(data);
        @(posedge clk);
        #1 coef_we = 1'b0;
        if (expect_taken && addr < TAPS) m_coef[addr] = data;
    endtask

    // Waits for the result of a sample accepted k0 negedges ago; checks latency,
    // busy window, value, flag and pulse width.
    task automatic wait_result(input string tag, input int k0);
        int lat;
        int rdy_bad;
        lat     = 0;
        rdy_bad = 0;
        for (int k = k0 + 1; k <= TAPS + 6 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) lat = k;
            else if (k <= TAPS + 1 && in_ready !== 1'b0) rdy_bad++;
        end
        chk({tag, "_lat"}, lat, TAPS + 2);
        chk({tag, "_busy"}, rdy_bad, 0);
        chk({tag, "_dout"}, 32'(dataout), exp_out);
        chk({tag, "_sat"}, 32'(sat), exp_sat);
        if (lat != 0) begin
            @(negedge clk);
            chk({tag, "_pulse"}, 32'(out_valid), 0);
        end
    endtask

    task automatic run_sample(input string tag, input int v);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 1);
        x        = DATA_W'(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_push(v);
        wait_result(tag, 0);
    endtask

    initial begin
        int q_exp_out [$];
        int q_exp_sat [$];
        int accepted, got, last_ov, ov_cnt;
        int v;

        rst = 1'b1; x = '0; in_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_dout", 32'(dataout), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_rdy", 32'(in_ready), 1);

        // Impulse through default coefficients
        run_sample("imp0", 255);
        chk("imp0_lit", 32'(dataout), 7);
        for (int i = 1; i < TAPS; i++) run_sample("imp", 0);
        chk("imp4_lit", 32'(dataout), 127);

        // Step response settles at 247
        do_reset();
        for (int i = 0; i < 6; i++) run_sample("step", 255);
        chk("step_lit", 32'(dataout), 247);

        // Saturation with full-scale coefficients, then drain
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 255, 1);
        for (int i = 0; i < TAPS; i++) run_sample("satu", 255);
        chk("satu_lit", 32'(dataout), 1023);
        chk("satu_flag", 32'(sat), 1);
        for (int i = 0; i < TAPS; i++) run_sample("drain", 0);
        chk("drain_lit", 32'(dataout), 0);

        // Back-to-back with in_valid held high
        do_reset();
        accepted = 0; got = 0; last_ov = -1; ov_cnt = 0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q_exp_out.size() > 0) begin
                    chk("b2b_dout", 32'(dataout), q_exp_out.pop_front());
                    chk("b2b_sat", 32'(sat), q_exp_sat.pop_front());
                end
                if (last_ov >= 0) chk("b2b_period", cyc - last_ov, TAPS + 2);
                last_ov = cyc;
                got++;
            end
            if (in_ready === 1'b1) begin
                if (accepted < 6) begin
                    v = int'($urandom_range(0, 255));
                    x = DATA_W'(v);
                    in_valid = 1'b1;
                    model_push(v);
                    q_exp_out.push_back(exp_out);
                    q_exp_sat.push_back(exp_sat);
                    accepted++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", got, 6);
        chk("b2b_left", q_exp_out.size(), 0);

        // Coefficient write in the same cycle as the first sample
        do_reset();
        @(negedge clk);
        coef_we = 1'b1; coef_addr = '0; coef_data = 8'd1;
        x = 8'd255; in_valid = 1'b1;
        @(posedge clk);
        #1 coef_we = 1'b0; in_valid = 1'b0;
        m_coef[0] = 1;
        model_push(255);
        wait_result("cw_same", 0);
        chk("cw_same_lit", 32'(dataout), 0);

        // Write during MAC is dropped
        @(negedge clk);
        x = 8'd200; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_push(200);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = AW'(1); coef_data = 8'd99;
        @(posedge clk);
        #1 coef_we = 1'b0;
        wait_result("cw_mac", 1);

        // Out-of-range address is dropped
        write_coef(7, 200, 0);
        run_sample("cw_addr7", 100);

        // Randomized coefficients and samples
        for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 255)), 1);
        for (int i = 0; i < 12; i++) run_sample("rand", int'($urandom_range(0, 255)));

        // Reset in the middle of accumulation aborts the result
        @(negedge clk);
        x = 8'd255; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ov_cnt = 0;
        for (int k = 0; k < TAPS + 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov_cnt++;
        end
        chk("abort_ov", ov_cnt, 0);
        chk("abort_dout", 32'(dataout), 0);
        chk("abort_sat", 32'(sat), 0);
        run_sample("abort_imp", 255);
        chk("abort_imp_lit", 32'(dataout), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
